// File: rtl/segre_pkg.sv
// Shared types and constants for the Segre pipeline.
//   IC_LINES / LINE_WORDS : default instruction cache geometry
//   NOP_INSTR             : instruction used for IF/ID bubbles and flushes
//   ic_line_t             : one cache line at the default geometry
//   if_state_t            : fetch stage refill FSM states
package segre_pkg;

    localparam int unsigned IC_LINES   = 4;
    localparam int unsigned LINE_WORDS = 4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef logic [32*LINE_WORDS-1:0] ic_line_t;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } if_state_t;

endpackage

// File: rtl/segre_icache_array.sv
// Direct-mapped instruction cache storage: per-line valid bit, tag and data.
//   clk, rst        : clock, asynchronous active-high reset (clears valid bits)
//   rd_idx          : combinational lookup index
//   rd_valid/tag/line : contents of the indexed line
//   we, wr_idx, wr_tag, wr_line : single write port; a write always sets valid
module segre_icache_array #(
    parameter int unsigned LINES  = 4,
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned TAG_W  = 26,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [LINE_W-1:0] rd_line,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [LINE_W-1:0] wr_line
);

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags  [LINES];
    logic [LINE_W-1:0] lines [LINES];

    // Only the valid bits need reset; tag/data are don't-care until valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_idx]  <= wr_tag;
            lines[wr_idx] <= wr_line;
        end
    end

    always_comb begin
        rd_valid = valid[rd_idx];
        rd_tag   = tags[rd_idx];
        rd_line  = lines[rd_idx];
    end

endmodule

// File: rtl/segre_if_stage.sv
// Segre instruction fetch stage: PC register, direct-mapped I-cache lookup,
// line refill FSM (valid/ready to memory) and the IF/ID pipeline register.
//   clk_i, rsn_i          : clock, asynchronous active-high reset
//   block_if_i            : controller stall (hold PC and IF/ID)
//   inject_nops_id_i      : controller bubble request for IF/ID
//   tkbr_i, new_pc_i      : taken-branch redirect from EX
//   ic_hit_o, valid_if_o  : current PC hits while in RUN
//   mem_rd_o, mem_addr_o  : line refill request and line-aligned address
//   mem_ready_i, mem_data_i : refill response (word 0 in bits [31:0])
//   instr_id_o, pc_id_o, valid_id_o : IF/ID register
module segre_if_stage #(
    parameter int unsigned           ADDR_SIZE  = 32,
    parameter int unsigned           IC_LINES   = 4,
    parameter int unsigned           LINE_WORDS = 4,
    parameter logic [ADDR_SIZE-1:0]  BOOT_ADDR  = '0
) (
    input  logic                      clk_i,
    input  logic                      rsn_i,
    input  logic                      block_if_i,
    input  logic                      inject_nops_id_i,
    input  logic                      tkbr_i,
    input  logic [ADDR_SIZE-1:0]      new_pc_i,
    output logic                      ic_hit_o,
    output logic                      valid_if_o,
    output logic                      mem_rd_o,
    output logic [ADDR_SIZE-1:0]      mem_addr_o,
    input  logic                      mem_ready_i,
    input  logic [32*LINE_WORDS-1:0]  mem_data_i,
    output logic [31:0]               instr_id_o,
    output logic [ADDR_SIZE-1:0]      pc_id_o,
    output logic                      valid_id_o
);

    import segre_pkg::*;

    localparam int unsigned OFF    = $clog2(4*LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(IC_LINES);
    localparam int unsigned TAG_W  = ADDR_SIZE - OFF - IDX_W;
    localparam int unsigned WSEL_W = OFF - 2;
    localparam int unsigned LINE_W = 32*LINE_WORDS;

    if_state_t               state;
    if_state_t               state_next;
    logic [ADDR_SIZE-1:0]    pc;
    logic [ADDR_SIZE-1:0]    miss_addr;

    logic [IDX_W-1:0]        pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic [WSEL_W-1:0]       pc_wsel;

    logic                    rd_valid;
    logic [TAG_W-1:0]        rd_tag;
    logic [LINE_W-1:0]       rd_line;
    logic [31:0]             fetch_word;

    logic                    hit;
    logic                    refill_we;
    logic                    unused_bits;

    // Redirect targets are word aligned; the low address bits are dropped.
    assign unused_bits = &{1'b0, new_pc_i[1:0]};

    assign pc_wsel = pc[OFF-1:2];
    assign pc_idx  = pc[OFF+IDX_W-1:OFF];
    assign pc_tag  = pc[ADDR_SIZE-1:OFF+IDX_W];

    segre_icache_array #(
        .LINES  (IC_LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_array (
        .clk      (clk_i),
        .rst      (rsn_i),
        .rd_idx   (pc_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .we       (refill_we),
        .wr_idx   (miss_addr[OFF+IDX_W-1:OFF]),
        .wr_tag   (miss_addr[ADDR_SIZE-1:OFF+IDX_W]),
        .wr_line  (mem_data_i)
    );

    assign hit        = (state == RUN) && rd_valid && (rd_tag == pc_tag);
    assign ic_hit_o   = hit;
    assign valid_if_o = hit;

    always_comb begin
        fetch_word = '0;
        for (int unsigned w = 0; w < LINE_WORDS; w++) begin
            if (pc_wsel == WSEL_W'(w)) begin
                fetch_word = rd_line[w*32 +: 32];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // FSM: next state. A refill, once started, always runs to completion.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (!hit)       state_next = MISS;
            MISS:    if (mem_ready_i) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // FSM: outputs. Both derive from the async-reset state, so the
    // request drops immediately when reset is asserted mid-refill.
    always_comb begin
        mem_rd_o  = 1'b0;
        refill_we = 1'b0;
        if (state == MISS) begin
            mem_rd_o  = 1'b1;
            refill_we = mem_ready_i;
        end
    end

    // The refill address is latched on entry to MISS so a redirect during
    // the refill does not disturb the outstanding request.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            miss_addr <= '0;
        end else if (state == RUN && !hit) begin
            miss_addr <= {pc[ADDR_SIZE-1:OFF], {OFF{1'b0}}};
        end
    end

    assign mem_addr_o = miss_addr;

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            pc <= BOOT_ADDR;
        end else if (tkbr_i) begin
            pc <= {new_pc_i[ADDR_SIZE-1:2], 2'b00};
        end else if (block_if_i) begin
            pc <= pc;
        end else if (hit) begin
            pc <= pc + ADDR_SIZE'(4);
        end
    end

    // IF/ID register; bubbles and flushes keep the previous pc_id.
    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            instr_id_o <= NOP_INSTR;
            pc_id_o    <= '0;
            valid_id_o <= 1'b0;
        end else if (tkbr_i || inject_nops_id_i) begin
            instr_id_o <= NOP_INSTR;
            valid_id_o <= 1'b0;
        end else if (block_if_i) begin
            valid_id_o <= valid_id_o;
        end else if (hit) begin
            instr_id_o <= fetch_word;
            pc_id_o    <= pc;
            valid_id_o <= 1'b1;
        end else begin
            instr_id_o <= NOP_INSTR;
            valid_id_o <= 1'b0;
        end
    end

endmodule

// File: doc/segre_if_stage.md
# segre_if_stage

Instruction fetch stage of the Segre pipeline: holds the PC and a small direct-mapped instruction cache, and refills missing lines from memory through a valid/ready handshake. It drives the IF/ID pipeline register consumed by decode. It reports hit status to the pipeline controller and obeys that controller's `block_if` and `inject_nops_id` commands. Branch redirects from EX enter here.

## Interface
Parameters:
- `ADDR_SIZE`, 32: PC/byte-address width.
- `IC_LINES`, 4: cache lines; power of two, ≥2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `BOOT_ADDR`, 32'h0000_0000: PC after reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` in 1: clock, rising edge.
- `rsn_i` in 1: reset, asynchronous, active-high.
- `block_if_i` in 1: controller stall; hold PC and IF/ID.
- `inject_nops_id_i` in 1: controller bubble request for IF/ID.
- `tkbr_i` in 1: taken branch/jump redirect from EX.
- `new_pc_i` in ADDR_SIZE: redirect target; bits [1:0] ignored.
- `ic_hit_o` out 1: current PC hits in RUN (to controller `ic_if_hit_i`).
- `valid_if_o` out 1: equals `ic_hit_o`.
- `mem_rd_o` out 1: line refill request.
- `mem_addr_o` out ADDR_SIZE: line-aligned refill address.
- `mem_ready_i` in 1: refill data valid this cycle.
- `mem_data_i` in 32*LINE_WORDS: refill line; word 0 in bits [31:0].
- `instr_id_o` out 32: IF/ID instruction.
- `pc_id_o` out ADDR_SIZE: IF/ID PC.
- `valid_id_o` out 1: IF/ID entry valid.

## Operation
- Address split: OFF = log2(4*LINE_WORDS), IDX = log2(IC_LINES). Word select is pc[OFF-1:2]. Index is pc[OFF+IDX-1:OFF]. Tag is pc[ADDR_SIZE-1:OFF+IDX].
- `ic_hit_o` is combinational: (state==RUN) && valid[idx] && tag[idx]==pc tag.
- FSM, two states:
  - RUN: a miss captures `miss_addr` = pc with bits [OFF-1:0] cleared, then moves to MISS at the next edge.
  - MISS: `mem_rd_o`=1 and `mem_addr_o`=`miss_addr`, both held stable until a cycle with `mem_ready_i`=1. At that edge the line is written, valid is set, and the state returns to RUN. A refill is never cancelled.
- PC update, in priority order:
  1. `tkbr_i`: pc := {new_pc_i[ADDR_SIZE-1:2],2'b0}. Applies in any state and overrides `block_if_i`.
  2. `block_if_i`: hold.
  3. hit: pc := pc+4, wrapping modulo 2^ADDR_SIZE.
  4. otherwise: hold.
- Redirect during MISS: the PC changes immediately. The old `miss_addr` refill still completes and installs. Lookup then uses the new PC.
- IF/ID update, in priority order:
  1. `tkbr_i`: flush.
  2. `inject_nops_id_i`: bubble.
  3. `block_if_i`: hold.
  4. hit: load {instruction word, pc, valid=1}.
  5. otherwise: bubble.
- A bubble or flush sets `instr_id_o`=NOP (32'h0000_0013), `valid_id_o`=0, and leaves `pc_id_o` unchanged.
- Memory responses are accepted only in MISS. `mem_ready_i` in RUN is ignored.

## Timing
- Reset values:
  - pc = BOOT_ADDR, all valid bits 0, state RUN.
  - `mem_rd_o`=0, `mem_addr_o`=0.
  - `instr_id_o`=NOP, `pc_id_o`=0, `valid_id_o`=0.
  - `ic_hit_o` is 0 because no line is valid.
- Hit: PC presented in cycle n gives the IF/ID entry valid in cycle n+1. Throughput is 1 instruction/cycle.
- Miss, detected in cycle 0:
  - `mem_rd_o` rises in cycle 1.
  - `mem_ready_i` arrives in cycle k≥1.
  - Cycle k+1 is RUN and hits.
  - `valid_id_o`=1 in cycle k+2. Minimum penalty is 2 cycles.
- Redirect in cycle n: `valid_id_o`=0 in n+1, and the target is fetched in n+1 if it hits.
- Reset asserted mid-refill: `mem_rd_o` drops without waiting for a clock edge, the line is not installed, and the state is RUN.
- Tag and valid are rewritten on every refill of an index (conflict eviction). There is no other invalidation.

## Structure
- `segre_pkg` additions:
  - `IC_LINES`, `LINE_WORDS`.
  - `NOP_INSTR` = 32'h0000_0013.
  - `ic_line_t` (packed 32*LINE_WORDS).
  - `if_state_t` enum {RUN, MISS}.
- Sub-module `segre_icache_array`: tag/valid/data storage with a combinational read port (index) and a single write port (index, tag, line, we). Its valid bits are reset asynchronously.
- The FSM, PC register and IF/ID register stay in `segre_if_stage`.

## Test plan
- Cold start, BOOT_ADDR=0, `mem_ready_i` in cycle 3 with words {A,B,C,D}:
  - `mem_rd_o` is high in cycles 1–3 with `mem_addr_o`=0.
  - IF/ID shows A@0, B@4, C@8, D@0xC on consecutive cycles from cycle 5.
- `block_if_i` held for 3 cycles mid-stream: `instr_id_o` and `pc_id_o` stay frozen and the PC does not advance. Streaming resumes with the next word.
- `tkbr_i` with `new_pc_i`=0x43 during a hit stream:
  - Next cycle `valid_id_o`=0.
  - The PC becomes 0x40, which misses.
  - The refill at 0x40 completes.
  - `pc_id_o`=0x40.
- Redirect to a cached address while in MISS for 0x100:
  - `mem_addr_o` stays 0x100 until ready.
  - The line at 0x100 is installed (a later fetch of 0x100 hits with no request).
  - The redirect target is fetched right after.
- Conflict, IC_LINES=4, LINE_WORDS=4:
  - Fetch 0x00, then 0x40, then 0x00 again.
  - Each access misses and issues a refill request.
- Reset asserted during MISS:
  - `mem_rd_o` falls asynchronously and `valid_id_o`=0.
  - After release, fetch restarts at BOOT_ADDR with a miss.
